// File: rtl/snes_reader.sv
// SNES controller poller: latch/clock generation and 16-bit button capture.
// Define SNES_PRESENT_DETECT_EN to add a 17th clock for controller detection.
module snes_reader #(
    parameter int unsigned LATCH_STEPS = 1,
    parameter int unsigned GAP_STEPS   = 1400,
    parameter int unsigned GAP_W       = 11
) (
    input  logic        clk_i,
    input  logic        reset,
    input  logic        div_clk_i,
    input  logic        snes_data_i,
    output logic        snes_latch_o,
    output logic        snes_clk_o,
    output logic [15:0] buttons_o,
    output logic        valid_o,
    output logic        present_o
);

`ifdef SNES_PRESENT_DETECT_EN
    localparam int unsigned NBITS = 17;
`else
    localparam int unsigned NBITS = 16;
`endif
    localparam int unsigned BIT_W = 5;

    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_STEPS - 1);
    localparam logic [GAP_W-1:0] LATCH_LAST = GAP_W'(LATCH_STEPS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(NBITS - 1);

    typedef enum logic [2:0] {
        S_GAP,
        S_LATCH,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [GAP_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [NBITS-1:0]   shift_q, shift_d;
    logic               latch_q, latch_d;
    logic               sclk_q, sclk_d;
    logic [15:0]        buttons_q, buttons_d;
    logic               valid_q, valid_d;
    logic               present_q, present_d;
    logic               div_q;
    logic               data_s1_q, data_s2_q;
    logic               step;

    assign step = div_clk_i & ~div_q;

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q   <= S_GAP;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            latch_q   <= 1'b0;
            sclk_q    <= 1'b1;
            buttons_q <= '0;
            valid_q   <= 1'b0;
            present_q <= 1'b0;
            div_q     <= 1'b0;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            latch_q   <= latch_d;
            sclk_q    <= sclk_d;
            buttons_q <= buttons_d;
            valid_q   <= valid_d;
            present_q <= present_d;
            div_q     <= div_clk_i;
            data_s1_q <= snes_data_i;
            data_s2_q <= data_s1_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        latch_d   = latch_q;
        sclk_d    = sclk_q;
        buttons_d = buttons_q;
        valid_d   = 1'b0;
        present_d = present_q;
        unique case (state_q)
            S_GAP: begin
                if (step) begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d   = '0;
                        latch_d = 1'b1;
                        state_d = S_LATCH;
                    end else begin
                        cnt_d = cnt_q + GAP_W'(1);
                    end
                end
            end
            S_LATCH: begin
                if (step) begin
                    if (cnt_q == LATCH_LAST) begin
                        cnt_d   = '0;
                        latch_d = 1'b0;
                        sclk_d  = 1'b0;
                        bit_d   = '0;
                        state_d = S_LOW;
                    end else begin
                        cnt_d = cnt_q + GAP_W'(1);
                    end
                end
            end
            S_LOW: begin
                if (step) begin
                    for (int i = 0; i < NBITS; i++) begin
                        if (bit_q == BIT_W'(i)) shift_d[i] = ~data_s2_q;
                    end
                    sclk_d  = 1'b1;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (step) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        sclk_d  = 1'b0;
                        state_d = S_LOW;
                    end
                end
            end
            S_DONE: begin
`ifdef SNES_PRESENT_DETECT_EN
                // A connected pad drives 0 after its 16 bits; stored inverted.
                present_d = shift_q[16];
                buttons_d = shift_q[16] ? shift_q[15:0] : 16'h0000;
`else
                present_d = 1'b1;
                buttons_d = shift_q[15:0];
`endif
                valid_d   = 1'b1;
                cnt_d     = '0;
                state_d   = S_GAP;
            end
            default: state_d = S_GAP;
        endcase
    end

    assign snes_latch_o = latch_q;
    assign snes_clk_o   = sclk_q;
    assign buttons_o    = buttons_q;
    assign valid_o      = valid_q;
    assign present_o    = present_q;

endmodule

// File: tb/tb_snes_reader.sv
// Bench for snes_reader: pad model on the serial lines, word/timing checks.
module tb_snes_reader;

    localparam int GAP_STEPS   = 4;
    localparam int LATCH_STEPS = 2;
`ifdef SNES_PRESENT_DETECT_EN
    localparam int NBITS = 17;
`else
    localparam int NBITS = 16;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        div_clk_i = 1'b0;
    logic        snes_data_i;
    logic        snes_latch_o;
    logic        snes_clk_o;
    logic [15:0] buttons_o;
    logic        valid_o;
    logic        present_o;

    int n_tests = 0;
    int n_fail  = 0;

    snes_reader #(
        .LATCH_STEPS(LATCH_STEPS),
        .GAP_STEPS  (GAP_STEPS),
        .GAP_W      (11)
    ) dut (
        .clk_i       (clk),
        .reset       (reset),
        .div_clk_i   (div_clk_i),
        .snes_data_i (snes_data_i),
        .snes_latch_o(snes_latch_o),
        .snes_clk_o  (snes_clk_o),
        .buttons_o   (buttons_o),
        .valid_o     (valid_o),
        .present_o   (present_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Divided-clock source; step_no counts rising edges the DUT will see.
    int   half = 1;
    int   div_cnt = 0;
    int   step_no = 0;
    logic step_pend = 1'b0;
    logic div_run = 1'b0;
    logic div_force_low = 1'b0;

    always @(negedge clk) begin
        step_pend = 1'b0;
        if (div_force_low) begin
            div_clk_i = 1'b0;
            div_cnt   = 0;
        end else if (div_run) begin
            div_cnt++;
            if (div_cnt >= half) begin
                div_cnt   = 0;
                div_clk_i = ~div_clk_i;
                if (div_clk_i) begin
                    step_no++;
                    step_pend = 1'b1;
                end
            end
        end
    end

    // Controller: latch reloads, each rising clk shifts the next bit out.
    logic        plugged = 1'b1;
    logic [15:0] next_word = 16'h0;
    logic [15:0] ctl_word = 16'h0;
    int          ctl_idx = 0;

    always @(posedge snes_clk_o or posedge snes_latch_o) begin
        if (snes_latch_o) begin
            ctl_idx  = 0;
            ctl_word = next_word;
        end else begin
            ctl_idx++;
        end
    end

    assign snes_data_i = !plugged ? 1'b1 :
                         (ctl_idx < 16) ? ctl_word[ctl_idx[3:0]] : 1'b0;

    // Waveform monitor
    logic p_latch = 1'b0, p_sclk = 1'b1, p_valid = 1'b0;
    int   lat_rise_step = 0, first_rise_step = 0, lat_rises = 0;
    int   t_fall = 0, t_rise = 0, falls = 0, rises = 0;
    logic in_xfer = 1'b0;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            lat_rises = 0;
            falls     = 0;
            rises     = 0;
            in_xfer   = 1'b0;
        end else begin
            if (snes_latch_o !== p_latch || snes_clk_o !== p_sclk)
                chk("step_only", 32'(step_pend), 32'd1);
            if (snes_latch_o && !p_latch) begin
                if (lat_rises == 0) first_rise_step = step_no;
                lat_rises++;
                lat_rise_step = step_no;
                falls   = 0;
                rises   = 0;
                in_xfer = 1'b1;
            end
            if (!snes_latch_o && p_latch) begin
                chk("latch_width", 32'(step_no - lat_rise_step), 32'(LATCH_STEPS));
                chk("clk_fall_at_latch_fall", 32'(snes_clk_o), 32'd0);
            end
            if (!snes_clk_o && p_sclk) begin
                falls++;
                if (falls > 1) chk("clk_high_w", 32'(step_no - t_rise), 32'd1);
                t_fall = step_no;
            end
            if (snes_clk_o && !p_sclk) begin
                rises++;
                chk("clk_low_w", 32'(step_no - t_fall), 32'd1);
                t_rise = step_no;
            end
            if (valid_o) begin
                chk("pulse_count", 32'(falls), 32'(NBITS));
                chk("valid_1cyc", 32'(p_valid), 32'd0);
                in_xfer = 1'b0;
            end
        end
        p_latch = snes_latch_o;
        p_sclk  = snes_clk_o;
        p_valid = valid_o;
    end

    int rel_step = 0;

    task automatic release_reset();
        @(negedge clk);
        div_run       = 1'b0;
        div_force_low = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        rel_step = step_no;
        @(negedge clk);
        div_force_low = 1'b0;
        div_run       = 1'b1;
    endtask

    task automatic finish_poll(input logic [15:0] w, input string tag);
        int n;
        logic [15:0] exp_b;
        logic        exp_p;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (valid_o !== 1'b1 && n < 4000);
        chk({tag, "_valid"}, 32'(valid_o), 32'd1);
        exp_b = plugged ? ~w : 16'h0000;
`ifdef SNES_PRESENT_DETECT_EN
        exp_p = plugged;
`else
        exp_p = 1'b1;
`endif
        chk({tag, "_buttons"}, 32'(buttons_o), 32'(exp_b));
        chk({tag, "_present"}, 32'(present_o), 32'(exp_p));
    endtask

    task automatic wait_xfer(input int min_rises, input int min_falls);
        int n;
        n = 0;
        while (!(in_xfer && rises >= min_rises && falls >= min_falls) && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("xfer_reached", 32'(n < 4000), 32'd1);
    endtask

    initial begin
        logic [15:0] w;
        logic        s_latch, s_sclk;
        logic [15:0] s_btn;

        reset = 1'b1;
        half  = 1;
        div_run = 1'b1;
        next_word = 16'h5A3C;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_latch", 32'(snes_latch_o), 32'd0);
            chk("rst_clk", 32'(snes_clk_o), 32'd1);
            chk("rst_buttons", 32'(buttons_o), 32'd0);
            chk("rst_valid", 32'(valid_o), 32'd0);
            chk("rst_present", 32'(present_o), 32'd0);
        end

        half = 3;
        release_reset();
        finish_poll(16'h5A3C, "poll0");
        chk("poll0_word", 32'(buttons_o), 32'h0000A5C3);
        chk("first_latch", 32'(first_rise_step - rel_step), 32'(GAP_STEPS));

        // Holds between pulses
        repeat (5) @(posedge clk);
        #1;
        chk("hold_buttons", 32'(buttons_o), 32'h0000A5C3);
        chk("hold_valid", 32'(valid_o), 32'd0);

        // Abort after bit 7 has been sampled
        w = 16'($urandom);
        next_word = w;
        wait_xfer(8, 0);
        @(negedge clk);
        reset = 1'b1;
        div_run = 1'b0;
        div_force_low = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_latch", 32'(snes_latch_o), 32'd0);
        chk("mid_clk", 32'(snes_clk_o), 32'd1);
        chk("mid_buttons", 32'(buttons_o), 32'd0);
        chk("mid_valid", 32'(valid_o), 32'd0);
        release_reset();
        finish_poll(w, "after_mid");
        chk("mid_first_latch", 32'(first_rise_step - rel_step), 32'(GAP_STEPS));

        // Freeze the divider partway through the bit train
        w = 16'($urandom);
        next_word = w;
        wait_xfer(0, 3);
        @(negedge clk);
        div_run = 1'b0;
        @(posedge clk);
        #1;
        s_latch = snes_latch_o;
        s_sclk  = snes_clk_o;
        s_btn   = buttons_o;
        repeat (500) @(posedge clk);
        #1;
        chk("stall_latch", 32'(snes_latch_o), 32'(s_latch));
        chk("stall_clk", 32'(snes_clk_o), 32'(s_sclk));
        chk("stall_buttons", 32'(buttons_o), 32'(s_btn));
        chk("stall_valid", 32'(valid_o), 32'd0);
        @(negedge clk);
        div_run = 1'b1;
        finish_poll(w, "stall");

        for (int i = 0; i < 4; i++) begin
            half = int'($urandom_range(5, 2));
            w = 16'($urandom);
            next_word = w;
            finish_poll(w, "rand");
        end

        // Line pulled high with nothing attached
        plugged = 1'b0;
        w = 16'($urandom);
        next_word = w;
        finish_poll(w, "unplugged");

        plugged = 1'b1;
        w = 16'($urandom);
        next_word = w;
        finish_poll(w, "replug");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
